// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM state type, funct3 encodings and access-size helpers for the load/store unit
package lsu_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_t;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   // any funct3 that is neither a byte nor a half access behaves as a word access
   function automatic logic is_byte(logic [2:0] f3);
      return f3 == F3_B || f3 == F3_BU;
   endfunction
   function automatic logic is_half(logic [2:0] f3);
      return f3 == F3_H || f3 == F3_HU;
   endfunction
   function automatic logic [3:0] be_for(logic [2:0] funct3, logic [1:0] addr_lo);
      return is_byte(funct3) ? 4'b0001 << addr_lo : is_half(funct3) ? 4'b0011 << addr_lo : 4'b1111;
   endfunction
endpackage

// File: rtl/load_align.sv
// load_align: picks the byte/half/word out of a bus read word and sign- or zero-extends it
//   rdata   in  32  word read from the bus
//   addr_lo in  2   byte offset of the access within the word
//   funct3  in  3   access size and sign (bit 2 set = zero-extend)
//   data    out 32  extended load value
module load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);
   logic [7:0]  b;
   logic [15:0] h;
   assign b = 8'(rdata >> {addr_lo, 3'b000});
   assign h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   assign data = is_byte(funct3) ? {{24{~funct3[2] & b[7]}}, b} :
                 is_half(funct3) ? {{16{~funct3[2] & h[15]}}, h} : rdata;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns core loads/stores into word-aligned bus transactions and stalls until ack
//   clk, reset            clock, synchronous active-high reset
//   MemRead, MemWrite     load / store request (both high = store)
//   funct3, Addr          access size/sign and byte address
//   StoreData             store value (rs2)
//   MemData               registered extended load result
//   Stall                 holds the pipeline while an access is in flight
//   MisalignedErr, BusErr one-cycle error pulses (misaligned access, bus timeout)
//   bus_*                 request/response handshake towards RAM and UART
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] Addr,
   input  logic [31:0] StoreData,
   output logic [31:0] MemData,
   output logic        Stall,
   output logic        MisalignedErr,
   output logic        BusErr,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);
   lsu_state_t  state_q, state_d;
   logic        we_q, err_q;
   logic [31:0] addr_q, wdata_q, md_q, cnt_q, ld_data, wdata_d;
   logic [3:0]  be_q;
   logic [2:0]  f3_q;
   logic [1:0]  lo_q;
   logic        req, mis, tmo;
   assign req = MemRead | MemWrite;
   assign mis = is_half(funct3) ? Addr[0] : !is_byte(funct3) && Addr[1:0] != 2'b00;
   // an ack in the same cycle as the limit is a normal completion, so it masks the abort
   assign tmo = TIMEOUT_CYCLES != 0 && cnt_q == 32'(TIMEOUT_CYCLES - 1) && !bus_ack;
   assign wdata_d = is_byte(funct3) ? {4{StoreData[7:0]}} :
                    is_half(funct3) ? {2{StoreData[15:0]}} : StoreData;
   always_comb begin
      state_d       = state_q;
      Stall         = 1'b0;
      MisalignedErr = 1'b0;
      if (state_q == IDLE) begin
         state_d       = req && !mis ? BUSY : IDLE;
         Stall         = req && !mis;
         MisalignedErr = req && mis;
      end else if (state_q == BUSY) begin
         state_d = bus_ack || tmo ? DONE : BUSY;
         Stall   = 1'b1;
      end else begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         f3_q    <= '0;
         lo_q    <= '0;
         md_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= state_q == BUSY && tmo;
         if (state_q == IDLE && state_d == BUSY) begin
            we_q    <= MemWrite;
            addr_q  <= {Addr[31:2], 2'b00};
            be_q    <= be_for(funct3, Addr[1:0]);
            wdata_q <= wdata_d;
            f3_q    <= funct3;
            lo_q    <= Addr[1:0];
            cnt_q   <= '0;
         end else if (state_q == BUSY && !bus_ack) begin
            cnt_q <= cnt_q + 32'd1;
         end
         if (state_q == BUSY && bus_ack && !we_q) md_q <= ld_data;
         else if (state_q == BUSY && tmo) md_q <= '0;
      end
   end
   load_align u_align (
      .rdata  (bus_rdata),
      .addr_lo(lo_q),
      .funct3 (f3_q),
      .data   (ld_data)
   );
   assign MemData   = md_q;
   assign BusErr    = err_q;
   assign bus_req   = state_q == BUSY;
   assign bus_we    = we_q;
   assign bus_addr  = addr_q;
   assign bus_be    = be_q;
   assign bus_wdata = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors with a request/response scoreboard for load_store_unit
module tb_load_store_unit;
   logic        clk = 1'b0;
   logic        reset, MemRead, MemWrite, Stall, MisalignedErr, BusErr, bus_req, bus_we, bus_ack;
   logic [2:0]  funct3;
   logic [31:0] Addr, StoreData, MemData, bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_be;
   int          checks = 0, failures = 0;
   logic [68:0] req_q[$];
   logic [32:0] rsp_q[$];
   logic [68:0] re;
   logic [32:0] rr;
   logic        prev_req = 1'b0;
   logic [31:0] exp_md;

   typedef struct {
      logic        rd, wr, we;
      logic [2:0]  f3;
      logic [31:0] a, sd, rdat;
      int          ackn;
      logic [3:0]  be;
      logic [31:0] wd;
      logic        err;
      logic [31:0] md;
      int          stalls;
   } vec_t;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
      .Addr(Addr), .StoreData(StoreData), .MemData(MemData), .Stall(Stall),
      .MisalignedErr(MisalignedErr), .BusErr(BusErr), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
      .bus_rdata(bus_rdata)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic miss(input string nm);
      checks++;
      failures++;
      $display("FAIL %s: got event expected none", nm);
   endtask

   always @(negedge clk) begin
      if (bus_req && !prev_req) begin
         if (req_q.size() == 0) miss("req_unexpected");
         else begin
            re = req_q.pop_front();
            chk("bus_we", 32'(bus_we), 32'(re[68]));
            chk("bus_addr", bus_addr, re[67:36]);
            chk("bus_be", 32'(bus_be), 32'(re[35:32]));
            chk("bus_wdata", bus_wdata, re[31:0]);
         end
      end else if (!bus_req && prev_req && !reset) begin
         if (rsp_q.size() == 0) miss("rsp_unexpected");
         else begin
            rr = rsp_q.pop_front();
            chk("MemData", MemData, rr[31:0]);
            chk("BusErr", 32'(BusErr), 32'(rr[32]));
         end
      end
      prev_req = bus_req;
   end

   task automatic run(input vec_t v);
      int  stalls, k;
      logic done;
      req_q.push_back({v.we, v.a & 32'hFFFF_FFFC, v.be, v.wd});
      rsp_q.push_back({v.err, v.md});
      exp_md = v.md;
      @(posedge clk); #1;
      MemRead = v.rd; MemWrite = v.wr; funct3 = v.f3; Addr = v.a; StoreData = v.sd; bus_ack = 1'b0;
      stalls = 0; k = 0; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (Stall) stalls++;
         if (bus_req) begin
            k++;
            if (k == v.ackn) begin bus_ack = 1'b1; bus_rdata = v.rdat; end
         end else if (k > 0) done = 1'b1;
         if (!done) begin @(posedge clk); #1; bus_ack = 1'b0; end
      end
      if (!done) miss("access_timeout");
      chk("stall_cycles", 32'(stalls), 32'(v.stalls));
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b0;
   endtask

   task automatic misaligned(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
      @(posedge clk); #1;
      MemRead = rd; MemWrite = wr; funct3 = f3; Addr = a;
      @(negedge clk);
      chk("mis_pulse", 32'(MisalignedErr), 32'd1);
      chk("mis_stall", 32'(Stall), 32'd0);
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b0;
      @(negedge clk);
      chk("mis_pulse_end", 32'(MisalignedErr), 32'd0);
      chk("mis_no_req", 32'(bus_req), 32'd0);
      chk("mis_memdata", MemData, exp_md);
   endtask

   vec_t vecs[$];
   vec_t tail[$];

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000; Addr = '0; StoreData = '0;
      bus_ack = 1'b0; bus_rdata = '0; exp_md = '0;
      vecs = '{
         '{1,0,0,3'b010,32'h100,0,32'hDEADBEEF,1,4'b1111,0,0,32'hDEADBEEF,2},
         '{1,0,0,3'b000,32'h103,0,32'h80FFFFFF,1,4'b1000,0,0,32'hFFFFFF80,2},
         '{1,0,0,3'b100,32'h103,0,32'h80FFFFFF,1,4'b1000,0,0,32'h00000080,2},
         '{1,0,0,3'b101,32'h102,0,32'hBEEF1234,3,4'b1100,0,0,32'h0000BEEF,4},
         '{1,0,0,3'b001,32'h100,0,32'h12348001,2,4'b0011,0,0,32'hFFFF8001,3},
         '{0,1,1,3'b000,32'h201,32'h000000A5,32'h0BADF00D,1,4'b0010,32'hA5A5A5A5,0,32'hFFFF8001,2},
         '{0,1,1,3'b001,32'h202,32'h1234CAFE,32'h0BADF00D,2,4'b1100,32'hCAFECAFE,0,32'hFFFF8001,3},
         '{0,1,1,3'b010,32'h300,32'h11223344,32'h0BADF00D,1,4'b1111,32'h11223344,0,32'hFFFF8001,2},
         '{1,1,1,3'b010,32'h304,32'h55667788,32'h0BADF00D,1,4'b1111,32'h55667788,0,32'hFFFF8001,2}
      };
      tail = '{
         '{1,0,0,3'b000,32'h101,0,32'h00007F00,1,4'b0010,0,0,32'h0000007F,2},
         '{1,0,0,3'b010,32'h400,0,32'h0,0,4'b1111,0,1,32'h00000000,5},
         '{1,0,0,3'b010,32'h404,0,32'h55AA55AA,1,4'b1111,0,0,32'h55AA55AA,2}
      };
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_MemData", MemData, 32'h0);
      chk("rst_Stall", 32'(Stall), 32'd0);
      chk("rst_Mis", 32'(MisalignedErr), 32'd0);
      chk("rst_BusErr", 32'(BusErr), 32'd0);
      chk("rst_bus_req", 32'(bus_req), 32'd0);
      chk("rst_bus_we", 32'(bus_we), 32'd0);
      chk("rst_bus_addr", bus_addr, 32'h0);
      chk("rst_bus_be", 32'(bus_be), 32'd0);
      chk("rst_bus_wdata", bus_wdata, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      foreach (vecs[i]) run(vecs[i]);
      misaligned(1, 0, 3'b010, 32'h102);
      misaligned(0, 1, 3'b001, 32'h201);
      misaligned(1, 0, 3'b101, 32'h103);
      foreach (tail[i]) run(tail[i]);
      @(negedge clk);
      chk("buserr_one_cycle", 32'(BusErr), 32'd0);
      req_q.push_back({1'b0, 32'h500, 4'b1111, 32'h0});
      @(posedge clk); #1;
      MemRead = 1'b1; funct3 = 3'b010; Addr = 32'h500; StoreData = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("busy2_req", 32'(bus_req), 32'd1);
      @(posedge clk); #1;
      MemRead = 1'b0;
      @(negedge clk);
      chk("rst_busy_req", 32'(bus_req), 32'd0);
      chk("rst_busy_stall", 32'(Stall), 32'd0);
      chk("rst_busy_buserr", 32'(BusErr), 32'd0);
      chk("rst_busy_memdata", MemData, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      bus_ack = 1'b1; bus_rdata = 32'h12345678;
      @(posedge clk); #1;
      bus_ack = 1'b0;
      @(negedge clk);
      chk("late_ack_memdata", MemData, 32'h0);
      chk("late_ack_req", 32'(bus_req), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("req_q_left", 32'(req_q.size()), 32'd0);
      chk("rsp_q_left", 32'(rsp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the execute stage and the data bus (data RAM plus memory-mapped UART). It turns core loads and stores into word-aligned bus transactions with byte enables. It stalls the core until the bus acknowledges. For loads it returns the byte-, half- or word-extracted, sign- or zero-extended value on `MemData`, which is the memory input of the write-back multiplexer.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles `BUSY` waits for `bus_ack` before aborting; 0 disables the timeout.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `MemRead`  in  1  load request from the current instruction.
- `MemWrite`  in  1  store request from the current instruction.
- `funct3`  in  3  access size and sign: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
- `Addr`  in  32  byte address (ALU result).
- `StoreData`  in  32  rs2 value for stores.
- `MemData`  out  32  extended load result, registered.
- `Stall`  out  1  freezes PC and pipeline registers while high.
- `MisalignedErr`  out  1  one-cycle pulse on a misaligned access.
- `BusErr`  out  1  one-cycle pulse on timeout.
- `bus_req`  out  1  transaction request.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  32  `{Addr[31:2],2'b00}`.
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  store data replicated into lanes.
- `bus_ack`  in  1  one-cycle completion strobe.
- `bus_rdata`  in  32  read word, valid when `bus_ack`=1.

## Operation
- FSM states: `IDLE`, `BUSY`, `DONE`.
- **`IDLE`, request without misalignment** (`MemRead|MemWrite` high, not misaligned):
  - `Stall`=1 combinationally.
  - Latch `bus_addr`, `bus_we`, `bus_be`, `bus_wdata`, `funct3`, and `Addr[1:0]`.
  - Next state `BUSY`.
- **`IDLE`, misaligned request** (LH/LHU/SH with `Addr[0]`=1, or LW/SW with `Addr[1:0]`≠0):
  - `MisalignedErr`=1 for that cycle, `Stall`=0.
  - No bus transaction; `MemData` is unchanged; stay in `IDLE`.
- **`MemRead` and `MemWrite` both high:** handled as a write. Loads have priority only when `MemWrite`=0.
- **`BUSY`:**
  - `bus_req`=1 and `Stall`=1; request outputs are held stable.
  - On `bus_ack`: for a read, `MemData` <= extract(`bus_rdata`); go to `DONE`.
  - On timeout: `BusErr` pulses in the `DONE` cycle, `MemData` <= 0, go to `DONE`.
- **`DONE`:**
  - `Stall`=0 and `bus_req`=0, so the core advances on this edge.
  - Always go to `IDLE`. The instruction still visible in this cycle is never re-issued.
- **Byte enables:**
  - Byte: `1<<Addr[1:0]`.
  - Half: `4'b0011<<Addr[1:0]`.
  - Word: `4'b1111`.
- **Write data:** SB replicates `StoreData[7:0]` ×4; SH replicates `StoreData[15:0]` ×2; SW passes through.
- **Extraction:**
  - Select the byte or half by the latched `Addr[1:0]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - An unknown `funct3` is treated as LW / SW.
- **Timeout counter:**
  - Cleared on entering `BUSY`; increments each `BUSY` cycle without ack.
  - Aborts when the count reaches `TIMEOUT_CYCLES` and `TIMEOUT_CYCLES`≠0.
  - A `bus_ack` in the same cycle as the timeout wins: it is a normal completion.
- `MemData` holds its value until the next completed load or a timeout.

## Timing
- Minimum access: 3 cycles (`IDLE`→`BUSY`→`DONE`) when `bus_ack` arrives in the first `BUSY` cycle.
- General access: 2 + N cycles for an ack in `BUSY` cycle N.
- `MemData` is valid from the `DONE` cycle onward and is sampled by write-back at the `DONE` edge.
- `bus_req` goes high the cycle after the request is seen and drops the cycle after `bus_ack`.
- A `bus_ack` in `IDLE` or `DONE` is ignored.
- **Reset:**
  - Reset values: state `IDLE`; `MemData`, `Stall`, `MisalignedErr`, `BusErr`, `bus_req`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata` and the counter all 0.
  - Reset in `BUSY` drops `bus_req` at the next edge with no error pulse.
  - A late ack after reset is ignored.

## Structure
- Package `lsu_pkg` holds:
  - the `lsu_state_t` enum;
  - `funct3` localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the function `be_for(funct3, addr_lo)`.
- Sub-module `load_align`: combinational extraction and extension from (`rdata`, `addr_lo`, `funct3`) to `data`. It is instantiated once.

## Test plan
- LW at 0x100, `bus_rdata`=0xDEADBEEF, ack in BUSY cycle 1:
  - `Stall` is high for 2 cycles.
  - `MemData`=0xDEADBEEF in `DONE`.
  - `bus_be`=1111, `bus_we`=0.
- LB at 0x103, rdata=0x80FFFFFF → `MemData`=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102, rdata=0xBEEF1234 → 0x0000BEEF.
- SB at 0x201, `StoreData`=0x000000A5 → `bus_addr`=0x200, `bus_be`=0010, `bus_wdata`=0xA5A5A5A5, `bus_we`=1.
- LW at 0x102 → `MisalignedErr` 1-cycle pulse, `Stall`=0, `bus_req` stays 0, `MemData` unchanged.
- `TIMEOUT_CYCLES`=4 and no ack:
  - `bus_req` is high for 4 cycles, then `BusErr` pulses and `MemData`=0.
  - A follow-up LW completes normally.
- Reset asserted in the 2nd `BUSY` cycle → `bus_req`=0 and state `IDLE` at the next edge. A subsequent ack is ignored and produces no `MemData` update.
